// File: rtl/reset_sequencer.sv
// Board-level SoC reset controller: merges power-on reset, a debounced push-button
// and PLL lock into one asynchronously-asserted, synchronously-released, stretched reset.
module reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned STRETCH_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_reset,
    input  logic       pll_locked,
    output logic       soc_rst_n,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [DW-1:0] DTERM = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STERM = SW'(STRETCH_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STRETCH,
        RUN
    } state_e;

    logic          btn_meta_q;
    logic          btn_sync_q;
    logic          lock_meta_q;
    logic          lock_sync_q;
    logic          btn_stable_q;
    logic          btn_stable_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic [SW-1:0] scnt_q;
    state_e        state_q;
    logic [1:0]    cause_q;
    logic [7:0]    count_q;
    logic          soc_rst_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            btn_meta_q  <= btn_reset;
            btn_sync_q  <= btn_meta_q;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Any return to the accepted level restarts the qualification window.
    always_comb begin
        btn_stable_d = btn_stable_q;
        dcnt_d       = '0;
        if (btn_sync_q != btn_stable_q) begin
            if (dcnt_q == DTERM) begin
                btn_stable_d = btn_sync_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable_q <= 1'b0;
            dcnt_q       <= '0;
        end else begin
            btn_stable_q <= btn_stable_d;
            dcnt_q       <= dcnt_d;
        end
    end

    // soc_rst_n_q mirrors (next state == RUN); it defaults low and is set only on RUN entry/stay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            scnt_q      <= '0;
            cause_q     <= CAUSE_POR;
            count_q     <= '0;
            soc_rst_n_q <= 1'b0;
        end else begin
            soc_rst_n_q <= 1'b0;
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_sync_q && !btn_stable_q) begin
                        state_q <= STRETCH;
                        scnt_q  <= '0;
                    end
                end
                STRETCH: begin
                    if (!lock_sync_q || btn_stable_q) begin
                        state_q <= WAIT_LOCK;
                    end else if (scnt_q == STERM) begin
                        state_q     <= RUN;
                        soc_rst_n_q <= 1'b1;
                    end else begin
                        scnt_q <= scnt_q + SW'(1);
                    end
                end
                RUN: begin
                    if (!lock_sync_q || btn_stable_q) begin
                        state_q <= WAIT_LOCK;
                        cause_q <= lock_sync_q ? CAUSE_BTN : CAUSE_LOCK;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end else begin
                        soc_rst_n_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign soc_rst_n   = soc_rst_n_q;
    assign reset_cause = cause_q;
    assign reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8.
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn_reset;
    logic       pll_locked;
    logic       soc_rst_n;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    int n_checks;
    int n_fails;
    logic [7:0] exp_count;

    reset_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .STRETCH_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_reset  (btn_reset),
        .pll_locked (pll_locked),
        .soc_rst_n  (soc_rst_n),
        .reset_cause(reset_cause),
        .reset_count(reset_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns 1 ns after the n-th following rising edge; inputs set here are first sampled one edge later.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic soc, input logic [1:0] cause,
                                 input logic [7:0] count);
        check({tag, "_soc"}, {7'd0, soc_rst_n}, {7'd0, soc});
        check({tag, "_cause"}, {6'd0, reset_cause}, {6'd0, cause});
        check({tag, "_count"}, reset_count, count);
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        exp_count  = 8'd0;
        rst_n      = 1'b0;
        btn_reset  = 1'b0;
        pll_locked = 1'b0;

        // 1. power-up
        adv(3);
        check_outputs("por_hold", 1'b0, 2'b00, 8'd0);
        rst_n = 1'b1;
        adv(2);
        pll_locked = 1'b1;
        adv(10);
        check_outputs("por_e9", 1'b0, 2'b00, 8'd0);
        adv(1);
        check_outputs("por_e10", 1'b1, 2'b00, 8'd0);

        // 2. lock loss in RUN, re-lock at e20
        pll_locked = 1'b0;
        adv(2);
        check_outputs("lock_e1", 1'b1, 2'b00, 8'd0);
        adv(1);
        exp_count = 8'd1;
        check_outputs("lock_e2", 1'b0, 2'b10, exp_count);
        adv(17);
        pll_locked = 1'b1;
        adv(10);
        check_outputs("relock_e29", 1'b0, 2'b10, exp_count);
        adv(1);
        check_outputs("relock_e30", 1'b1, 2'b10, exp_count);

        // 3. 3-cycle glitch is rejected, then a held press
        btn_reset = 1'b1;
        adv(3);
        btn_reset = 1'b0;
        adv(12);
        check_outputs("glitch", 1'b1, 2'b10, exp_count);
        btn_reset = 1'b1;
        adv(6);
        check_outputs("press_e5", 1'b1, 2'b10, exp_count);
        adv(1);
        exp_count = 8'd2;
        check_outputs("press_e6", 1'b0, 2'b01, exp_count);
        adv(30);
        check_outputs("press_held", 1'b0, 2'b01, exp_count);
        btn_reset = 1'b0;
        adv(14);
        check_outputs("release_r13", 1'b0, 2'b01, exp_count);
        adv(2);
        check_outputs("release_r15", 1'b1, 2'b01, exp_count);

        // 4. button and lock loss reach the FSM on the same edge (b0+6)
        btn_reset = 1'b1;
        adv(4);
        pll_locked = 1'b0;
        adv(2);
        check_outputs("both_b5", 1'b1, 2'b01, exp_count);
        adv(1);
        exp_count = 8'd3;
        check_outputs("both_b6", 1'b0, 2'b10, exp_count);
        adv(10);
        check_outputs("both_after", 1'b0, 2'b10, exp_count);
        btn_reset  = 1'b0;
        pll_locked = 1'b1;
        adv(20);
        check_outputs("both_recover", 1'b1, 2'b10, exp_count);

        // 5. lock glitch seen while STRETCH holds scnt=5
        pll_locked = 1'b0;
        adv(3);
        exp_count = 8'd4;
        check_outputs("s5_drop", 1'b0, 2'b10, exp_count);
        adv(5);
        pll_locked = 1'b1;
        adv(6);
        pll_locked = 1'b0;
        adv(1);
        pll_locked = 1'b1;
        adv(4);
        check_outputs("s5_l10", 1'b0, 2'b10, exp_count);
        adv(6);
        check_outputs("s5_l16", 1'b0, 2'b10, exp_count);
        adv(1);
        check_outputs("s5_l17", 1'b1, 2'b10, exp_count);

        // 6. saturate the run-time reset counter
        for (int i = 0; i < 250; i++) begin
            btn_reset = 1'b1;
            adv(8);
            btn_reset = 1'b0;
            adv(16);
        end
        check_outputs("sat_254", 1'b1, 2'b01, 8'd254);
        for (int i = 0; i < 6; i++) begin
            btn_reset = 1'b1;
            adv(8);
            btn_reset = 1'b0;
            adv(16);
        end
        check_outputs("sat_255", 1'b1, 2'b01, 8'd255);

        // Asynchronous reset in the middle of STRETCH
        btn_reset = 1'b1;
        adv(8);
        btn_reset = 1'b0;
        adv(10);
        check_outputs("mid_stretch", 1'b0, 2'b01, 8'd255);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 2'b00, 8'd0);
        adv(2);
        rst_n = 1'b1;
        adv(11);
        check_outputs("post_rst_run", 1'b1, 2'b00, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
